// File: rtl/ulpi_axis_tx_pkg.sv
// ulpi_axis_tx_pkg: shared constants, state encoding and TX CMD helper
// for the link-side ULPI transmit path.
package ulpi_axis_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_STOP,
        S_DRAIN
    } tx_state_t;

    localparam logic [3:0] TXCMD_PID_DEF  = 4'h4;
    localparam logic [7:0] ABORT_BYTE_DEF = 8'hFF;
    localparam logic [7:0] NOOP           = 8'h00;

    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_DATA0 = 8'hC3;

    function automatic logic [7:0] txcmd(
        input logic [3:0] prefix,
        input logic [3:0] pid
    );
        return {prefix, pid};
    endfunction

endpackage

// File: rtl/ulpi_axis_tx.sv
// ulpi_axis_tx: AXI-Stream packet bytes to ULPI TX CMD + data + STP,
// with bus turnaround, PHY pre-emption and underrun abort handling.
module ulpi_axis_tx
    import ulpi_axis_tx_pkg::*;
#(
    parameter logic [3:0] TXCMD_PID  = TXCMD_PID_DEF,
    parameter logic [7:0] ABORT_BYTE = ABORT_BYTE_DEF
) (
    input  logic       ulpi_clock_i,
    input  logic       reset,
    input  logic       ulpi_dir_i,
    input  logic       ulpi_nxt_i,
    output logic       ulpi_stp_o,
    output logic [7:0] ulpi_data_o,
    output logic       ulpi_data_oe,
    input  logic       s_tvalid_i,
    output logic       s_tready_o,
    input  logic       s_tlast_i,
    input  logic [7:0] s_tdata_i,
    output logic       tx_busy_o,
    output logic       tx_abort_o
);

    tx_state_t state;
    logic      dir_q;
    logic      last_q;
    logic      go;
    logic      sent;

    assign go           = s_tvalid_i && !ulpi_dir_i && !dir_q;
    assign sent         = ulpi_nxt_i && !ulpi_dir_i;
    assign ulpi_data_oe = !ulpi_dir_i && !dir_q;
    assign tx_busy_o    = (state != S_IDLE);

    always_comb begin
        s_tready_o = 1'b0;
        if (!reset) begin
            unique case (state)
                S_IDLE:        s_tready_o = go;
                S_CMD, S_DATA: s_tready_o = sent && !last_q;
                S_DRAIN:       s_tready_o = 1'b1;
                default:       s_tready_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge ulpi_clock_i) begin
        if (reset) begin
            state       <= S_IDLE;
            dir_q       <= 1'b0;
            last_q      <= 1'b0;
            ulpi_stp_o  <= 1'b0;
            ulpi_data_o <= NOOP;
            tx_abort_o  <= 1'b0;
        end else begin
            dir_q      <= ulpi_dir_i;
            ulpi_stp_o <= 1'b0;
            tx_abort_o <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    ulpi_data_o <= NOOP;
                    if (go) begin
                        ulpi_data_o <= txcmd(TXCMD_PID, s_tdata_i[3:0]);
                        last_q      <= s_tlast_i;
                        state       <= S_CMD;
                    end
                end
                S_CMD, S_DATA: begin
                    // dir beats nxt: a byte accepted under dir was not sent
                    if (ulpi_dir_i) begin
                        tx_abort_o  <= 1'b1;
                        ulpi_data_o <= NOOP;
                        state       <= last_q ? S_IDLE : S_DRAIN;
                    end else if (ulpi_nxt_i) begin
                        if (last_q) begin
                            ulpi_stp_o  <= 1'b1;
                            ulpi_data_o <= NOOP;
                            state       <= S_STOP;
                        end else if (s_tvalid_i) begin
                            ulpi_data_o <= s_tdata_i;
                            last_q      <= s_tlast_i;
                            state       <= S_DATA;
                        end else begin
                            ulpi_stp_o  <= 1'b1;
                            ulpi_data_o <= ABORT_BYTE;
                            tx_abort_o  <= 1'b1;
                            state       <= S_DRAIN;
                        end
                    end
                end
                S_STOP: begin
                    ulpi_data_o <= NOOP;
                    state       <= S_IDLE;
                end
                S_DRAIN: begin
                    ulpi_data_o <= NOOP;
                    if (s_tvalid_i && s_tlast_i) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    ulpi_data_o <= NOOP;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule
